neuron_lut_loader: RTL and testbench
====================================

# neuron_lut_loader

Runtime-programmable replacement for a fixed truth-table neuron. Accepts a stream of truth-table entries on a valid/ready load port, writes them in ascending address order into a distributed-RAM table of 2^IN_BITS × OUT_BITS, then answers lookups on the same M0/M1 port shape a generated neuron uses. It sits wherever a compiled neuron would sit, so a layer can be re-weighted without re-synthesis. It is the writer-side counterpart to the combinational lookup.

## Interface
- IN_BITS, 4, lookup address width; the table holds 2^IN_BITS entries (legal 1..8).
- OUT_BITS, 2, width of each table entry (legal 1..8).

- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- load_start  in  1  one-cycle request to begin (or restart) a table load.
- ld_valid  in  1  ld_data holds an entry.
- ld_ready  out  1  loader accepts an entry this cycle.
- ld_data  in  OUT_BITS  table entry for the current load address.
- ld_done  out  1  one-cycle pulse: the full table has been written.
- loaded  out  1  table is complete and lookups are live.
- M0  in  IN_BITS  lookup address; bit ordering is identical to a compiled neuron's M0.
- M1  out  OUT_BITS  lookup result.

## Operation
- States: EMPTY, LOAD, READY. Reset enters EMPTY.
- EMPTY: ld_ready=0, loaded=0, M1=0. load_start → LOAD.
- LOAD:
  - ld_ready=1, loaded=0, M1=0.
  - A beat is accepted when ld_valid && ld_ready. The accepted ld_data is written to table[addr], then addr increments.
  - addr starts at 0 and ends at 2^IN_BITS−1.
  - Acceptance at addr = 2^IN_BITS−1 → READY.
  - load_start during LOAD restarts at addr=0. A beat in that same cycle is discarded.
- READY:
  - loaded=1, ld_ready=0, M1 = table[M0].
  - load_start → LOAD; loaded drops and M1 reads 0 until the reload completes.
- addr is IN_BITS+1 bits wide so the last-beat compare does not wrap.
- With IN_BITS=4 the counter ends at 15.
- Table contents are not cleared by rst or by load_start. Stale contents are never observable, because M1 is forced to 0 whenever loaded=0.
- ld_valid while ld_ready=0: ignored, no write.
- ld_data is sampled only on accepted beats.

## Timing
- Reset values: ld_ready=0, ld_done=0, loaded=0, M1=0, addr=0, state EMPTY.
- rst mid-load → EMPTY next cycle; the partial table is never exposed.
- ld_ready, ld_done and loaded are registered outputs.
- load_start sampled in cycle T → ld_ready=1 in T+1.
- Last beat accepted in cycle T:
  - T+1: ld_ready=0, loaded=1, ld_done=1 (one cycle only).
  - First valid lookup is in T+1.
- Full load with ld_valid held high takes 2^IN_BITS cycles of ld_ready (16 with defaults).
- load_start and a final beat in the same cycle: load_start wins. The beat is discarded, addr=0, and no ld_done is produced.
- Lookup latency in READY: combinational without the macro, or 1 cycle with it (see Configuration).

## Configuration
- NEURON_LUT_LOADER_REG_OUT_EN defined:
  - M1 is registered: M1(T+1) = table[M0(T)] if loaded(T), else 0.
  - Reset value of M1 is 0.
  - After ld_done, the first correct M1 appears one cycle after M0 is presented.
- Undefined:
  - M1 = loaded ? table[M0] : 0, combinational.
  - Drop-in timing match for a compiled neuron.

## Test plan
- Reset then idle → ld_ready=0, loaded=0, M1=0, ld_done never pulses; ld_valid=1 with ld_data=3 produces no write.
- load_start, then 16 back-to-back beats (defaults) with entry=01 at addresses 0,4,8,9,12,13 and 00 elsewhere:
  - ld_ready=1 for exactly 16 cycles.
  - ld_done pulses once in the cycle after beat 15; loaded=1 from then on.
  - Sweep M0 0..15: M1=01 at 0,4,8,9,12,13 and 00 elsewhere.
- Same load with ld_valid toggling 1-0-1-0 → 16 beats accepted over 31 cycles; table and ld_done identical to the back-to-back case.
- In READY, load_start then 5 beats of 11, then rst → loaded=0 and M1=0 next cycle.
  - A new full load of all-10 → every M0 returns 10.
  - No beat of 11 from the aborted load is visible.
- During LOAD at addr=7, assert load_start together with a beat of 11:
  - The beat is dropped and addr restarts at 0.
  - ld_done comes only after 16 further beats; table[7] holds the value from the restarted load.
- Macro defined:
  - M0=4 presented in T yields M1=01 in T+1; M0 changes in the same cycle T do not alter M1 until T+1.
  - After rst, M1=0.

Source files
------------

// File: rtl/neuron_lut_loader.sv
// neuron_lut_loader: runtime-loadable truth table standing in for a compiled neuron.
// Latency: M1 combinational from M0 (1 cycle when NEURON_LUT_LOADER_REG_OUT_EN is defined).
// Backpressure: ld_ready is high only in LOAD; entries offered at any other time are ignored.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   load_start        one-cycle request to begin or restart a table load
//   ld_valid/ld_ready valid/ready handshake for table entries
//   ld_data           entry written at the current load address on an accepted beat
//   ld_done           one-cycle pulse after the last entry is written
//   loaded            table complete, lookups live
//   M0 / M1           lookup address / result (same shape as a compiled neuron)
//
// Optional feature: define NEURON_LUT_LOADER_REG_OUT_EN to register M1.
module neuron_lut_loader #(
   parameter int IN_BITS  = 4,
   parameter int OUT_BITS = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load_start,
   input  logic                ld_valid,
   output logic                ld_ready,
   input  logic [OUT_BITS-1:0] ld_data,
   output logic                ld_done,
   output logic                loaded,
   input  logic [IN_BITS-1:0]  M0,
   output logic [OUT_BITS-1:0] M1
);

   localparam int DEPTH = 1 << IN_BITS;
   // One spare bit so the last-address compare never sees a wrapped counter.
   localparam int AW = IN_BITS + 1;
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      LOAD  = 2'd1,
      READY = 2'd2
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [AW-1:0]        addr;
   logic [AW-1:0]        addr_nxt;
   logic                 beat;
   logic                 wr_en;
   logic                 done_nxt;
   logic                 ready_nxt;
   logic                 loaded_nxt;
   logic [OUT_BITS-1:0]  lut_mem [DEPTH];
   logic [OUT_BITS-1:0]  lut_rd;

   // ld_ready is high exactly in LOAD, so it doubles as the acceptance gate.
   assign beat = ld_valid && ld_ready;

   // ---------------------------------------------------------------
   // State register (also holds the registered handshake outputs)
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= EMPTY;
         addr     <= '0;
         ld_ready <= 1'b0;
         loaded   <= 1'b0;
         ld_done  <= 1'b0;
      end else begin
         state    <= state_nxt;
         addr     <= addr_nxt;
         ld_ready <= ready_nxt;
         loaded   <= loaded_nxt;
         ld_done  <= done_nxt;
      end
   end

   // ---------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      addr_nxt  = addr;
      wr_en     = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         EMPTY: begin
            if (load_start) begin
               state_nxt = LOAD;
               addr_nxt  = '0;
            end
         end
         LOAD: begin
            // A restart outranks a beat in the same cycle: the beat is
            // dropped, and a final beat cannot complete the load.
            if (load_start) begin
               addr_nxt = '0;
            end else if (beat) begin
               wr_en = 1'b1;
               if (addr == LAST_ADDR) begin
                  state_nxt = READY;
                  done_nxt  = 1'b1;
                  addr_nxt  = '0;
               end else begin
                  addr_nxt = addr + AW'(1);
               end
            end
         end
         READY: begin
            if (load_start) begin
               state_nxt = LOAD;
               addr_nxt  = '0;
            end
         end
         default: begin
            state_nxt = EMPTY;
            addr_nxt  = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Output logic: next values of the registered status outputs
   // ---------------------------------------------------------------
   always_comb begin
      ready_nxt  = 1'b0;
      loaded_nxt = 1'b0;
      case (state_nxt)
         LOAD:    ready_nxt  = 1'b1;
         READY:   loaded_nxt = 1'b1;
         default: begin
            ready_nxt  = 1'b0;
            loaded_nxt = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Table storage. Deliberately not cleared: stale entries are hidden
   // because M1 is forced to zero whenever loaded is low.
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (wr_en && !rst) begin
         lut_mem[addr[IN_BITS-1:0]] <= ld_data;
      end
   end

   assign lut_rd = lut_mem[M0];

`ifdef NEURON_LUT_LOADER_REG_OUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         M1 <= '0;
      end else begin
         M1 <= loaded ? lut_rd : '0;
      end
   end
`else
   // Combinational lookup keeps timing identical to a compiled neuron.
   always_comb begin
      M1 = loaded ? lut_rd : '0;
   end
`endif

endmodule

// File: tb/tb_neuron_lut_loader.sv
module tb_neuron_lut_loader;

   localparam int IN_BITS  = 4;
   localparam int OUT_BITS = 2;
   localparam int DEPTH    = 16;
   localparam int WDOG_CYCLES = 20000;

   logic                clk = 1'b0;
   logic                rst;
   logic                load_start;
   logic                ld_valid;
   logic                ld_ready;
   logic [OUT_BITS-1:0] ld_data;
   logic                ld_done;
   logic                loaded;
   logic [IN_BITS-1:0]  M0;
   logic [OUT_BITS-1:0] M1;

   always #5 clk = ~clk;

   neuron_lut_loader #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) dut (
      .clk(clk), .rst(rst), .load_start(load_start),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
      .ld_done(ld_done), .loaded(loaded), .M0(M0), .M1(M1)
   );

   // Selectors for what the monitor compares against
   localparam int SEL_M1     = 0;
   localparam int SEL_LOADED = 1;
   localparam int SEL_READY  = 2;
   localparam int SEL_DONES  = 3;
   localparam int SEL_RDYCYC = 4;

   typedef struct {
      int    sel;
      int    exp;
      string name;
   } chk_t;

   chk_t sbq[$];
   logic smp     = 1'b0;
   logic clr_cnt = 1'b0;
   logic tb_done = 1'b0;
   int   done_cnt  = 0;
   int   ready_cnt = 0;
   int   n_run  = 0;
   int   n_fail = 0;

   // Monitor: tracks ld_done pulses / ld_ready cycles and drains the
   // scoreboard whenever the driver flags the outputs as presented.
   always @(negedge clk) begin
      if (clr_cnt) begin
         done_cnt  = 0;
         ready_cnt = 0;
      end else begin
         if (ld_done)  done_cnt++;
         if (ld_ready) ready_cnt++;
      end
      if (smp) begin
         while (sbq.size() > 0) begin : pop
            chk_t c;
            int   act;
            c = sbq.pop_front();
            case (c.sel)
               SEL_M1:     act = int'(M1);
               SEL_LOADED: act = int'(loaded);
               SEL_READY:  act = int'(ld_ready);
               SEL_DONES:  act = done_cnt;
               default:    act = ready_cnt;
            endcase
            n_run++;
            if (act != c.exp) begin
               n_fail++;
               $display("FAIL %s: got %0d, expected %0d", c.name, act, c.exp);
            end
         end
      end
   end

   // Watchdog: the sequence must complete within a bounded number of cycles.
   initial begin : watchdog
      int cyc;
      cyc = 0;
      while (!tb_done && cyc < WDOG_CYCLES) begin
         @(posedge clk);
         cyc++;
      end
      n_run++;
      if (!tb_done) begin
         n_fail++;
         $display("FAIL watchdog: wait expired after %0d cycles", cyc);
         $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
         $finish;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      smp     = 1'b0;
      clr_cnt = 1'b0;
   endtask

   task automatic chk(input int sel, input int exp, input string name);
      chk_t c;
      c.sel  = sel;
      c.exp  = exp;
      c.name = name;
      sbq.push_back(c);
      smp = 1'b1;
   endtask

   task automatic do_load(input logic [1:0] v [DEPTH], input bit toggle);
      tick();
      load_start = 1'b1;
      clr_cnt    = 1'b1;
      chk(SEL_READY, 0, "ready_before_start");
      tick();
      load_start = 1'b0;
      chk(SEL_READY, 1, "ready_after_start");
      for (int i = 0; i < DEPTH; i++) begin
         ld_valid = 1'b1;
         ld_data  = v[i];
         if (i == DEPTH - 1) chk(SEL_LOADED, 0, "loaded_during_load");
         tick();
         if (toggle && i < DEPTH - 1) begin
            ld_valid = 1'b0;
            ld_data  = 2'b11;
            tick();
         end
      end
      ld_valid = 1'b0;
      ld_data  = 2'b11;
      chk(SEL_DONES, 1, "done_pulse");
      chk(SEL_RDYCYC, toggle ? 31 : 16, "ready_cycles");
      chk(SEL_LOADED, 1, "loaded_after_done");
      chk(SEL_READY, 0, "ready_after_done");
      tick();
      chk(SEL_DONES, 1, "done_single_cycle");
      chk(SEL_LOADED, 1, "loaded_hold");
   endtask

   task automatic sweep(input logic [1:0] v [DEPTH], input string tag);
      for (int m = 0; m < DEPTH; m++) begin
         M0 = 4'(m);
`ifdef NEURON_LUT_LOADER_REG_OUT_EN
         tick();
`endif
         chk(SEL_M1, int'(v[m]), $sformatf("%s_m0_%0d", tag, m));
         tick();
      end
   endtask

   logic [1:0] tab_a   [DEPTH];
   logic [1:0] tab_10  [DEPTH];
   logic [1:0] tab_mod [DEPTH];

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         tab_a[i]   = (i == 0 || i == 4 || i == 8 || i == 9 || i == 12 || i == 13) ? 2'b01 : 2'b00;
         tab_10[i]  = 2'b10;
         tab_mod[i] = 2'(i % 3);
      end
      rst        = 1'b1;
      load_start = 1'b0;
      ld_valid   = 1'b0;
      ld_data    = '0;
      M0         = '0;
      tick();
      tick();
      rst = 1'b0;

      // Direct reset-state check
      n_run++;
      if (ld_ready !== 1'b0 || loaded !== 1'b0 || ld_done !== 1'b0 || M1 !== '0) begin
         n_fail++;
         $display("FAIL reset_state: ld_ready=%b loaded=%b ld_done=%b M1=%b",
                  ld_ready, loaded, ld_done, M1);
      end

      // Reset state, then idle with an offered entry that must be ignored
      M0 = 4'd4;
      chk(SEL_READY, 0, "reset_ready");
      chk(SEL_LOADED, 0, "reset_loaded");
      chk(SEL_M1, 0, "reset_m1");
      clr_cnt  = 1'b1;
      ld_valid = 1'b1;
      ld_data  = 2'b11;
      for (int i = 0; i < 5; i++) tick();
      ld_valid = 1'b0;
      chk(SEL_RDYCYC, 0, "idle_no_ready");
      chk(SEL_DONES, 0, "idle_no_done");
      chk(SEL_LOADED, 0, "idle_loaded");
      chk(SEL_M1, 0, "idle_m1");

      // Back-to-back load of pattern A
      do_load(tab_a, 1'b0);
      tick();
      sweep(tab_a, "b2b");

`ifdef NEURON_LUT_LOADER_REG_OUT_EN
      // M1 follows the previous cycle's M0
      M0 = 4'd1;
      tick();
      M0 = 4'd4;
      chk(SEL_M1, 0, "reg_prev_m0");
      tick();
      M0 = 4'd5;
      chk(SEL_M1, 1, "reg_m0_4");
      tick();
`endif

      // Aborted reload (5 beats of 11) then reset
      tick();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      ld_valid   = 1'b1;
      ld_data    = 2'b11;
      for (int i = 0; i < 5; i++) tick();
      ld_valid = 1'b0;
      rst      = 1'b1;
      M0       = 4'd0;
      tick();
      rst = 1'b0;
      chk(SEL_LOADED, 0, "abort_loaded");
      chk(SEL_M1, 0, "abort_m1");
      chk(SEL_READY, 0, "abort_ready");
      do_load(tab_10, 1'b0);
      tick();
      sweep(tab_10, "all10");

      // Toggled-valid load of pattern A
      do_load(tab_a, 1'b1);
      tick();
      sweep(tab_a, "toggle");

      // Restart at addr 7 with a colliding beat of 11
      tick();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      ld_valid   = 1'b1;
      ld_data    = 2'b11;
      for (int i = 0; i < 7; i++) tick();
      load_start = 1'b1;
      clr_cnt    = 1'b1;
      tick();
      load_start = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         ld_valid = 1'b1;
         ld_data  = tab_mod[i];
         if (i == DEPTH - 1) begin
            chk(SEL_DONES, 0, "restart_no_early_done");
            chk(SEL_LOADED, 0, "restart_not_loaded");
         end
         tick();
      end
      ld_valid = 1'b0;
      chk(SEL_DONES, 1, "restart_done");
      chk(SEL_RDYCYC, 16, "restart_ready_cycles");
      chk(SEL_LOADED, 1, "restart_loaded");
      tick();
      sweep(tab_mod, "restart");

      tick();
      tick();
      tb_done = 1'b1;
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
